stage_if: RTL and testbench
===========================

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is sampled on clock.
REQ-004 IMem_Addr  output  32  fetch address; SHALL equal PC and stay stable while IMem_Req is high.
REQ-005 IMem_Req  output  1  fetch request, level-held until IMem_Ack.
REQ-006 IMem_Ack  input  1  single-cycle completion strobe; IMem_Data is valid in the same cycle.
REQ-007 IMem_Data  input  32  fetched instruction word.
REQ-008 Stall  input  1  ID stage not consuming; SHALL hold the End* outputs.
REQ-009 Branch_Taken  input  1  one-cycle redirect pulse.
REQ-010 Branch_Target  input  32  redirect address; bits [1:0] SHALL be ignored and forced to 0.
REQ-011 EndStageIF_Inst  output  32  registered instruction to ID.
REQ-012 EndStageIF_NewPC  output  32  registered fetch address + 4 of that instruction.
REQ-013 EndStageIF_Valid  output  1  registered; 0 marks a bubble.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, HOLD and DROP; IMem_Req SHALL be 1 in FETCH and DROP only.
REQ-015 IDLE SHALL move to FETCH unconditionally on the first clock edge after reset deasserts.
REQ-016 In FETCH with IMem_Ack=1, Stall=0 and Branch_Taken=0: the output register SHALL load {Inst=IMem_Data, NewPC=PC+4, Valid=1}, PC SHALL become PC+4, and the state SHALL stay FETCH (back-to-back fetch, one instruction per cycle at zero-wait memory).
REQ-017 In FETCH with IMem_Ack=1, Stall=1 and Branch_Taken=0: IMem_Data and PC+4 SHALL go to a one-entry hold buffer, the output register SHALL hold, PC SHALL become PC+4, and the state SHALL go to HOLD.
REQ-018 In HOLD with Stall=0 and Branch_Taken=0: the output register SHALL load the buffer with Valid=1, and the state SHALL go to FETCH.
REQ-019 In HOLD with Stall=1, all registers SHALL hold.
REQ-020 When Stall=0 and no instruction is delivered in a cycle, EndStageIF_Valid SHALL become 0 on the next edge.
REQ-021 When Stall=1, EndStageIF_Inst, EndStageIF_NewPC and EndStageIF_Valid SHALL hold, except under REQ-022.
REQ-022 Branch_Taken=1 SHALL take priority over Stall and Ack:
  - Valid SHALL clear on the next edge.
  - The hold buffer SHALL be discarded.
  - PC SHALL load Branch_Target.
REQ-023 Branch_Taken in FETCH with IMem_Ack=0 SHALL go to DROP; IMem_Addr SHALL keep the old address until Ack.
REQ-024 Branch_Taken in FETCH with IMem_Ack=1 SHALL discard IMem_Data and stay in FETCH at the target.
REQ-025 Branch_Taken in HOLD SHALL go to FETCH at the target.
REQ-026 In DROP, IMem_Ack SHALL discard the data and go to FETCH at the latched target.
REQ-027 A further Branch_Taken in DROP SHALL overwrite the latched target.
REQ-028 Branch_Taken in IDLE SHALL be ignored.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-030 While reset=0:
  - state=IDLE, PC=RESET_PC, latched target=0.
  - Buffer, EndStageIF_Inst and EndStageIF_NewPC = 0; EndStageIF_Valid=0.
  - IMem_Req=0 immediately, without waiting for a clock edge.
REQ-031 An Ack belonging to a request cut off by reset SHALL be ignored; after deassertion, the first IMem_Req SHALL appear one cycle later with IMem_Addr=RESET_PC.

Verification
REQ-032 Reset release, Ack tied to Req, Stall=0 -> addresses 0,4,8; Valid=1 from cycle 3; NewPC=4,8,C paired with the correct words.
REQ-033 Ack with Stall=1 for 3 cycles, instruction at 0x10 -> Req low during HOLD; Inst/NewPC hold the old values; the word from 0x10 emerges with NewPC=0x14 one cycle after Stall falls.
REQ-034 Branch_Taken to 0x40 while a request to 0x20 waits 2 cycles for Ack -> Addr holds 0x20 until Ack; the 0x20 data is never Valid; the next Req has Addr=0x40.
REQ-035 Branch_Taken, Stall and Ack all high in one cycle -> Valid=0 next cycle; the next Addr equals Target with bits [1:0] cleared (target 0x43 -> 0x40).
REQ-036 PC=0xFFFF_FFFC fetched -> NewPC=0x0000_0000 and the next Addr=0.
REQ-037 reset pulsed low mid-request -> Req drops asynchronously; Valid=0; the late Ack is ignored; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/stage_if_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
// Signals: IMem_Addr/IMem_Req driven by the fetch side, IMem_Ack/IMem_Data by memory.
// IMem_Req is level-held until a single-cycle IMem_Ack; IMem_Data is valid with IMem_Ack.
interface stage_if_if;
  logic [31:0] IMem_Addr;
  logic        IMem_Req;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;

  modport master (
    output IMem_Addr,
    output IMem_Req,
    input  IMem_Ack,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Addr,
    input  IMem_Req,
    output IMem_Ack,
    output IMem_Data
  );
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: walks the PC, fetches over imem, hands words to ID via a registered slot.
// Latency: one instruction per cycle at zero-wait memory; fetched word appears on End* one edge after Ack.
// Backpressure: Stall holds End*; a word arriving under Stall parks in a one-entry buffer (no new Req).
// Ports: clock, reset (async active-low), imem (fetch bus master), Stall, Branch_Taken,
//        Branch_Target, EndStageIF_Inst/NewPC/Valid (registered outputs to ID).
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  stage_if_if.master         imem,
  input  logic               Stall,
  input  logic               Branch_Taken,
  input  logic [31:0]        Branch_Target,
  output logic [31:0]        EndStageIF_Inst,
  output logic [31:0]        EndStageIF_NewPC,
  output logic               EndStageIF_Valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;     // redirect address latched while an abandoned request drains
  logic [31:0] buf_inst;
  logic [31:0] buf_newpc;
  logic [31:0] pc_plus4;
  logic [31:0] br_addr;

  assign pc_plus4 = pc + 32'd4;                       // wraps modulo 2^32
  assign br_addr  = Branch_Target & ~32'd3;

  // Address stays on the old PC during DROP so the in-flight request is not disturbed.
  assign imem.IMem_Addr = pc;
  // Decoded straight from the state register, so reset drops it without a clock edge.
  assign imem.IMem_Req  = (state == FETCH) || (state == DROP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      target           <= 32'd0;
      buf_inst         <= 32'd0;
      buf_newpc        <= 32'd0;
      EndStageIF_Inst  <= 32'd0;
      EndStageIF_NewPC <= 32'd0;
      EndStageIF_Valid <= 1'b0;
    end else begin
      case (state)
        // Any Ack seen here belongs to a request cut off by reset; ignore it.
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (Branch_Taken) begin
            EndStageIF_Valid <= 1'b0;
            if (imem.IMem_Ack) begin
              pc <= br_addr;                          // returned word is wrong-path, drop it
            end else begin
              target <= br_addr;                      // must wait for the outstanding Ack
              state  <= DROP;
            end
          end else if (imem.IMem_Ack) begin
            pc <= pc_plus4;
            if (!Stall) begin
              EndStageIF_Inst  <= imem.IMem_Data;
              EndStageIF_NewPC <= pc_plus4;
              EndStageIF_Valid <= 1'b1;
            end else begin
              buf_inst  <= imem.IMem_Data;
              buf_newpc <= pc_plus4;
              state     <= HOLD;
            end
          end else if (!Stall) begin
            EndStageIF_Valid <= 1'b0;                 // nothing delivered: bubble
          end
        end

        HOLD: begin
          if (Branch_Taken) begin
            EndStageIF_Valid <= 1'b0;
            buf_inst         <= 32'd0;
            buf_newpc        <= 32'd0;
            pc               <= br_addr;
            state            <= FETCH;
          end else if (!Stall) begin
            EndStageIF_Inst  <= buf_inst;
            EndStageIF_NewPC <= buf_newpc;
            EndStageIF_Valid <= 1'b1;
            state            <= FETCH;
          end
        end

        DROP: begin
          if (Branch_Taken || !Stall) begin
            EndStageIF_Valid <= 1'b0;
          end
          if (imem.IMem_Ack) begin
            // A branch arriving together with the Ack is the newest redirect.
            pc    <= Branch_Taken ? br_addr : target;
            state <= FETCH;
          end else if (Branch_Taken) begin
            target <= br_addr;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = 32'd0;
  logic [31:0] inst_o;
  logic [31:0] newpc_o;
  logic        valid_o;
  logic        tie = 1'b0;        // 1: memory acks every request in the same cycle
  logic        ack_reg = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  stage_if_if bus();
  assign bus.IMem_Ack  = tie ? bus.IMem_Req : ack_reg;
  assign bus.IMem_Data = word(bus.IMem_Addr);

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem             (bus),
    .Stall            (Stall),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .EndStageIF_Inst  (inst_o),
    .EndStageIF_NewPC (newpc_o),
    .EndStageIF_Valid (valid_o)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; tie = 1'b1;
    tick; tick;
    checks++; if (bus.IMem_Req !== 1'b0) begin errs++; $display("FAIL reset_req got %b want 0", bus.IMem_Req); end
    checks++; if (bus.IMem_Addr !== 32'h0) begin errs++; $display("FAIL reset_addr got %h want 0", bus.IMem_Addr); end
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (inst_o !== 32'h0) begin errs++; $display("FAIL reset_inst got %h want 0", inst_o); end
    checks++; if (newpc_o !== 32'h0) begin errs++; $display("FAIL reset_newpc got %h want 0", newpc_o); end
  endtask

  task automatic test_sequential;
    reset = 1'b1;
    tick;
    checks++; if (bus.IMem_Req !== 1'b1) begin errs++; $display("FAIL seq_first_req got %b want 1", bus.IMem_Req); end
    checks++; if (bus.IMem_Addr !== 32'h0) begin errs++; $display("FAIL seq_first_addr got %h want 0", bus.IMem_Addr); end
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL seq_first_valid got %b want 0", valid_o); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (bus.IMem_Addr !== 32'((i + 1) * 4)) begin errs++; $display("FAIL seq_addr%0d got %h want %h", i, bus.IMem_Addr, (i + 1) * 4); end
      checks++; if (valid_o !== 1'b1) begin errs++; $display("FAIL seq_valid%0d got %b want 1", i, valid_o); end
      checks++; if (inst_o !== word(32'(i * 4))) begin errs++; $display("FAIL seq_inst%0d got %h want %h", i, inst_o, word(32'(i * 4))); end
      checks++; if (newpc_o !== 32'((i + 1) * 4)) begin errs++; $display("FAIL seq_newpc%0d got %h want %h", i, newpc_o, (i + 1) * 4); end
    end
    tick;
    checks++; if (bus.IMem_Addr !== 32'h10) begin errs++; $display("FAIL seq_addr_10 got %h want 10", bus.IMem_Addr); end
  endtask

  task automatic test_stall;
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (bus.IMem_Req !== 1'b0) begin errs++; $display("FAIL stall_req%0d got %b want 0", k, bus.IMem_Req); end
      checks++; if (inst_o !== word(32'hC)) begin errs++; $display("FAIL stall_inst%0d got %h want %h", k, inst_o, word(32'hC)); end
      checks++; if (newpc_o !== 32'h10) begin errs++; $display("FAIL stall_newpc%0d got %h want 10", k, newpc_o); end
      checks++; if (valid_o !== 1'b1) begin errs++; $display("FAIL stall_valid%0d got %b want 1", k, valid_o); end
    end
    Stall = 1'b0;
    tick;
    checks++; if (inst_o !== word(32'h10)) begin errs++; $display("FAIL unstall_inst got %h want %h", inst_o, word(32'h10)); end
    checks++; if (newpc_o !== 32'h14) begin errs++; $display("FAIL unstall_newpc got %h want 14", newpc_o); end
    checks++; if (valid_o !== 1'b1) begin errs++; $display("FAIL unstall_valid got %b want 1", valid_o); end
    checks++; if (bus.IMem_Addr !== 32'h14) begin errs++; $display("FAIL unstall_addr got %h want 14", bus.IMem_Addr); end
    tick; tick; tick;
    checks++; if (bus.IMem_Addr !== 32'h20) begin errs++; $display("FAIL pre_branch_addr got %h want 20", bus.IMem_Addr); end
  endtask

  task automatic test_branch_wait;
    tie = 1'b0; ack_reg = 1'b0;
    Branch_Taken = 1'b1; Branch_Target = 32'h40;
    tick;
    Branch_Taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (bus.IMem_Addr !== 32'h20) begin errs++; $display("FAIL drop_addr%0d got %h want 20", k, bus.IMem_Addr); end
      checks++; if (bus.IMem_Req !== 1'b1) begin errs++; $display("FAIL drop_req%0d got %b want 1", k, bus.IMem_Req); end
      checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL drop_valid%0d got %b want 0", k, valid_o); end
      if (k == 0) tick;
    end
    ack_reg = 1'b1;
    tick;
    ack_reg = 1'b0;
    checks++; if (bus.IMem_Addr !== 32'h40) begin errs++; $display("FAIL redirect_addr got %h want 40", bus.IMem_Addr); end
    checks++; if (bus.IMem_Req !== 1'b1) begin errs++; $display("FAIL redirect_req got %b want 1", bus.IMem_Req); end
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL dropped_valid got %b want 0", valid_o); end
    tick;
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL dropped_valid2 got %b want 0", valid_o); end
  endtask

  task automatic test_branch_priority;
    tie = 1'b1;
    tick;
    checks++; if (valid_o !== 1'b1) begin errs++; $display("FAIL prio_pre_valid got %b want 1", valid_o); end
    tie = 1'b0; ack_reg = 1'b1; Stall = 1'b1;
    Branch_Taken = 1'b1; Branch_Target = 32'h43;
    tick;
    ack_reg = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL prio_valid got %b want 0", valid_o); end
    checks++; if (bus.IMem_Addr !== 32'h40) begin errs++; $display("FAIL prio_addr got %h want 40", bus.IMem_Addr); end
    checks++; if (bus.IMem_Req !== 1'b1) begin errs++; $display("FAIL prio_req got %b want 1", bus.IMem_Req); end
  endtask

  task automatic test_wrap;
    ack_reg = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFC;
    tick;
    ack_reg = 1'b0; Branch_Taken = 1'b0;
    checks++; if (bus.IMem_Addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr got %h want fffffffc", bus.IMem_Addr); end
    tie = 1'b1;
    tick;
    checks++; if (newpc_o !== 32'h0) begin errs++; $display("FAIL wrap_newpc got %h want 0", newpc_o); end
    checks++; if (inst_o !== word(32'hFFFF_FFFC)) begin errs++; $display("FAIL wrap_inst got %h want %h", inst_o, word(32'hFFFF_FFFC)); end
    checks++; if (bus.IMem_Addr !== 32'h0) begin errs++; $display("FAIL wrap_next_addr got %h want 0", bus.IMem_Addr); end
    tick;
    tie = 1'b0;
    tick;
    checks++; if (bus.IMem_Addr !== 32'h4) begin errs++; $display("FAIL wrap_then_addr got %h want 4", bus.IMem_Addr); end
  endtask

  task automatic test_reset_mid;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.IMem_Req !== 1'b0) begin errs++; $display("FAIL midrst_req got %b want 0", bus.IMem_Req); end
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL midrst_valid got %b want 0", valid_o); end
    checks++; if (bus.IMem_Addr !== 32'h0) begin errs++; $display("FAIL midrst_addr got %h want 0", bus.IMem_Addr); end
    ack_reg = 1'b1;               // late Ack of the cut-off request
    tick;
    checks++; if (bus.IMem_Req !== 1'b0) begin errs++; $display("FAIL midrst_req2 got %b want 0", bus.IMem_Req); end
    reset = 1'b1;
    tick;
    checks++; if (bus.IMem_Req !== 1'b1) begin errs++; $display("FAIL restart_req got %b want 1", bus.IMem_Req); end
    checks++; if (bus.IMem_Addr !== 32'h0) begin errs++; $display("FAIL restart_addr got %h want 0", bus.IMem_Addr); end
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL restart_valid got %b want 0", valid_o); end
    ack_reg = 1'b0;
    tick;
    checks++; if (bus.IMem_Addr !== 32'h0) begin errs++; $display("FAIL restart_addr2 got %h want 0", bus.IMem_Addr); end
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL restart_valid2 got %b want 0", valid_o); end
  endtask

  // Random traffic against a transaction-level model of the fetch stage.
  task automatic test_random;
    logic [31:0] m_pc, m_redir, o_inst, o_npc, t, w, n;
    logic        m_started, m_kill, o_vld, exp_req;
    logic [63:0] holdq[$];
    bit          a, s, b;
    reset = 1'b0; tie = 1'b0; ack_reg = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
    tick; tick;
    reset = 1'b1;
    m_pc = 32'h0; m_redir = 32'h0; m_started = 1'b0; m_kill = 1'b0;
    o_inst = 32'h0; o_npc = 32'h0; o_vld = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_req = m_started && (holdq.size() == 0);
      checks++; if (bus.IMem_Req !== exp_req) begin errs++; $display("FAIL rnd_req cyc%0d got %b want %b", cyc, bus.IMem_Req, exp_req); end
      checks++; if (bus.IMem_Addr !== m_pc) begin errs++; $display("FAIL rnd_addr cyc%0d got %h want %h", cyc, bus.IMem_Addr, m_pc); end
      checks++; if (valid_o !== o_vld) begin errs++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, valid_o, o_vld); end
      checks++; if (inst_o !== o_inst) begin errs++; $display("FAIL rnd_inst cyc%0d got %h want %h", cyc, inst_o, o_inst); end
      checks++; if (newpc_o !== o_npc) begin errs++; $display("FAIL rnd_newpc cyc%0d got %h want %h", cyc, newpc_o, o_npc); end
      b = ($urandom_range(7) == 0);
      s = ($urandom_range(2) == 0);
      a = exp_req && ($urandom_range(1) == 1);
      case ($urandom_range(3))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: t = 32'($urandom_range(255));
      endcase
      ack_reg = a; Stall = s; Branch_Taken = b; Branch_Target = t;
      @(posedge clock);
      t = t & ~32'd3;
      if (!m_started) begin
        m_started = 1'b1;
      end else if (b) begin
        o_vld = 1'b0;
        holdq.delete();
        if (!exp_req)  m_pc = t;
        else if (a)    begin m_pc = t; m_kill = 1'b0; end
        else           begin m_kill = 1'b1; m_redir = t; end
      end else if (a) begin
        if (m_kill) begin
          m_pc = m_redir; m_kill = 1'b0;
          if (!s) o_vld = 1'b0;
        end else begin
          w = word(m_pc); n = m_pc + 32'd4; m_pc = n;
          if (!s) begin o_inst = w; o_npc = n; o_vld = 1'b1; end
          else holdq.push_back({w, n});
        end
      end else if (holdq.size() > 0) begin
        if (!s) begin {o_inst, o_npc} = holdq.pop_front(); o_vld = 1'b1; end
      end else if (!s) begin
        o_vld = 1'b0;
      end
      #1;
    end
    ack_reg = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_branch_wait;
    test_branch_priority;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
